// File: rtl/rx_flow_ctrl_if.sv
// Signal bundle between the UART receiver, rx_flow_ctrl and the consuming host logic.
// The slave modport is the buffer's view; master is the receiver/consumer side.
interface rx_flow_ctrl_if #(
   parameter int DATA_BITS = 8,
   parameter int DEPTH     = 8
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic                 Data_Rdy_In;
   logic [DATA_BITS-1:0] Rx_Data_In;
   logic [2:0]           Rx_Error_In;
   logic                 RTS;
   logic                 Rd_Valid;
   logic                 Rd_Ready;
   logic [DATA_BITS-1:0] Rd_Data;
   logic [2:0]           Rd_Error;
   logic [LW-1:0]        Level;
   logic                 Overrun;
   logic [7:0]           Parity_Cnt;
   logic [7:0]           Frame_Cnt;
   logic [7:0]           Break_Cnt;
   logic                 Clr_Stats;

   modport master (
      output Data_Rdy_In, Rx_Data_In, Rx_Error_In, Rd_Ready, Clr_Stats,
      input  RTS, Rd_Valid, Rd_Data, Rd_Error, Level, Overrun,
             Parity_Cnt, Frame_Cnt, Break_Cnt
   );

   modport slave (
      input  Data_Rdy_In, Rx_Data_In, Rx_Error_In, Rd_Ready, Clr_Stats,
      output RTS, Rd_Valid, Rd_Data, Rd_Error, Level, Overrun,
             Parity_Cnt, Frame_Cnt, Break_Cnt
   );
endinterface

// File: rtl/rx_flow_ctrl.sv
// Receive buffer behind the UART receiver: show-ahead frame FIFO, RTS hysteresis with
// break hold-off, saturating error statistics and a sticky overrun flag.
module rx_flow_ctrl #(
   parameter int DATA_BITS     = 8,
   parameter int DEPTH         = 8,
   parameter int RTS_OFF_LEVEL = 6,
   parameter int RTS_ON_LEVEL  = 2,
   parameter int BREAK_HOLD    = 16
) (
   input logic           Clk,
   input logic           Rst,
   rx_flow_ctrl_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int HW = $clog2(BREAK_HOLD + 1);
   localparam logic [LW-1:0] OFF_LVL   = LW'(RTS_OFF_LEVEL);
   localparam logic [LW-1:0] ON_LVL    = LW'(RTS_ON_LEVEL);
   localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
   localparam logic [HW-1:0] HOLD_INIT = HW'(BREAK_HOLD - 1);

   typedef enum logic [1:0] {RUN, HOLD, BRK} rts_state_e;

   typedef struct packed {
      logic [2:0]           err;
      logic [DATA_BITS-1:0] data;
   } entry_t;

   entry_t        mem [DEPTH];
   entry_t        head;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] level, level_nxt;
   logic [7:0]    cnt [3];
   logic          overrun;
   logic          valid;
   logic          do_read, do_write, drop, brk_frame;
   rts_state_e    state;
   logic          rts;
   logic [HW-1:0] hold_cnt;

   // A full FIFO still accepts a frame when the head leaves in the same cycle.
   always_comb begin
      valid     = (level != '0);
      do_read   = valid && bus.Rd_Ready;
      do_write  = bus.Data_Rdy_In && ((level != FULL_LVL) || do_read);
      drop      = bus.Data_Rdy_In && !do_write;
      brk_frame = bus.Data_Rdy_In && bus.Rx_Error_In[2];
      level_nxt = level + LW'(do_write) - LW'(do_read);
   end

   // NOTE: storage is deliberately left out of reset; pointers and level alone decide visibility.
   always_ff @(posedge Clk) begin
      if (do_write && Rst) mem[wr_ptr] <= {bus.Rx_Error_In, bus.Rx_Data_In};
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_write) wr_ptr <= wr_ptr + AW'(1);
         if (do_read)  rd_ptr <= rd_ptr + AW'(1);
         level <= level_nxt;
      end
   end

   // Dropped frames still count; a clear wins over any same-cycle update.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         cnt     <= '{default: '0};
         overrun <= 1'b0;
      end else if (bus.Clr_Stats) begin
         cnt     <= '{default: '0};
         overrun <= 1'b0;
      end else begin
         if (drop) overrun <= 1'b1;
         for (int i = 0; i < 3; i++) begin
            if (bus.Data_Rdy_In && bus.Rx_Error_In[i] && (cnt[i] != 8'hFF))
               cnt[i] <= cnt[i] + 8'd1;
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state    <= RUN;
         rts      <= 1'b1;
         hold_cnt <= '0;
      end else if (brk_frame) begin
         state    <= BRK;
         rts      <= 1'b0;
         hold_cnt <= HOLD_INIT;
      end else begin
         unique case (state)
            RUN: begin
               if (level_nxt >= OFF_LVL) begin
                  state <= HOLD;
                  rts   <= 1'b0;
               end
            end
            HOLD: begin
               if (level_nxt <= ON_LVL) begin
                  state <= RUN;
                  rts   <= 1'b1;
               end
            end
            BRK: begin
               if (hold_cnt == '0) begin
                  if (level_nxt > ON_LVL) begin
                     state <= HOLD;
                     rts   <= 1'b0;
                  end else begin
                     state <= RUN;
                     rts   <= 1'b1;
                  end
               end else begin
                  hold_cnt <= hold_cnt - HW'(1);
               end
            end
            default: begin
               state <= RUN;
               rts   <= 1'b1;
            end
         endcase
      end
   end

   assign head           = mem[rd_ptr];
   assign bus.RTS        = rts;
   assign bus.Rd_Valid   = valid;
   assign bus.Rd_Data    = valid ? head.data : '0;
   assign bus.Rd_Error   = valid ? head.err : '0;
   assign bus.Level      = level;
   assign bus.Overrun    = overrun;
   assign bus.Parity_Cnt = cnt[0];
   assign bus.Frame_Cnt  = cnt[1];
   assign bus.Break_Cnt  = cnt[2];
endmodule

// File: tb/tb_rx_flow_ctrl.sv
// Self-checking bench for rx_flow_ctrl: directed scenarios plus random traffic, all
// compared against a queue-based behavioural model by a negedge monitor.
module tb_rx_flow_ctrl;
   localparam int DATA_BITS  = 8;
   localparam int DEPTH      = 8;
   localparam int OFF        = 6;
   localparam int ON         = 2;
   localparam int BREAK_HOLD = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   rx_flow_ctrl_if #(.DATA_BITS(DATA_BITS), .DEPTH(DEPTH)) bus ();

   rx_flow_ctrl #(
      .DATA_BITS(DATA_BITS), .DEPTH(DEPTH), .RTS_OFF_LEVEL(OFF),
      .RTS_ON_LEVEL(ON), .BREAK_HOLD(BREAK_HOLD)
   ) dut (
      .Clk(clk),
      .Rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: the FIFO is a queue, RTS is a throttle flag plus a low-time countdown.
   logic [10:0] q [$];
   int          m_cnt [3];
   bit          m_ovr;
   bit          m_throttled;
   int          m_brk_left;
   bit          m_rts;

   task automatic model_reset();
      q.delete();
      m_cnt       = '{0, 0, 0};
      m_ovr       = 1'b0;
      m_throttled = 1'b0;
      m_brk_left  = 0;
      m_rts       = 1'b1;
   endtask

   initial model_reset();

   always @(negedge clk) begin
      logic [10:0] f;
      if (!rst) model_reset();
      check("level", bus.Level, q.size());
      check("rd_valid", bus.Rd_Valid, q.size() != 0);
      check("rts", bus.RTS, m_rts);
      check("overrun", bus.Overrun, m_ovr);
      check("parity_cnt", bus.Parity_Cnt, m_cnt[0]);
      check("frame_cnt", bus.Frame_Cnt, m_cnt[1]);
      check("break_cnt", bus.Break_Cnt, m_cnt[2]);
      if (rst) begin
         if (bus.Rd_Valid && bus.Rd_Ready) begin
            if (q.size() == 0) begin
               check("rd_unexpected", 1, 0);
            end else begin
               f = q.pop_front();
               check("rd_data", bus.Rd_Data, f[7:0]);
               check("rd_error", bus.Rd_Error, f[10:8]);
            end
         end
         if (bus.Data_Rdy_In) begin
            if (q.size() < DEPTH) q.push_back({bus.Rx_Error_In, bus.Rx_Data_In});
            else m_ovr = 1'b1;
            for (int b = 0; b < 3; b++)
               if (bus.Rx_Error_In[b] && m_cnt[b] < 255) m_cnt[b]++;
         end
         if (bus.Clr_Stats) begin
            m_cnt = '{0, 0, 0};
            m_ovr = 1'b0;
         end
         if (bus.Data_Rdy_In && bus.Rx_Error_In[2]) begin
            m_brk_left = BREAK_HOLD;
         end else if (m_brk_left > 0) begin
            m_brk_left--;
            if (m_brk_left == 0) m_throttled = (q.size() > ON);
         end else if (!m_throttled && q.size() >= OFF) begin
            m_throttled = 1'b1;
         end else if (m_throttled && q.size() <= ON) begin
            m_throttled = 1'b0;
         end
         m_rts = (m_brk_left == 0) && !m_throttled;
      end
   end

   task automatic step(input bit dr, input logic [7:0] d, input logic [2:0] e,
                       input bit rdy, input bit clr);
      bus.Data_Rdy_In = dr;
      bus.Rx_Data_In  = d;
      bus.Rx_Error_In = e;
      bus.Rd_Ready    = rdy;
      bus.Clr_Stats   = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 8'h00, 3'b000, 1'b0, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < 2 * DEPTH && bus.Level != 0; i++) step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0);
      check("drain_empty", bus.Level, 0);
   endtask

   task automatic measure_low(output int n);
      n = 0;
      while (bus.RTS == 1'b0 && n < 64) begin
         n++;
         idle(1);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          n;
      int          rdy_pct;
      bit          dr, rdy, clr;
      logic [2:0]  e;

      bus.Data_Rdy_In = 1'b0;
      bus.Rx_Data_In  = '0;
      bus.Rx_Error_In = '0;
      bus.Rd_Ready    = 1'b0;
      bus.Clr_Stats   = 1'b0;
      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rts", bus.RTS, 1);
      check("rst_valid", bus.Rd_Valid, 0);
      check("rst_level", bus.Level, 0);
      check("rst_overrun", bus.Overrun, 0);
      check("rst_rd_data", bus.Rd_Data, 0);
      check("rst_rd_error", bus.Rd_Error, 0);
      rst = 1'b1;

      // Hysteresis
      for (int i = 1; i <= 6; i++) begin
         step(1'b1, 8'(i), 3'b000, 1'b0, 1'b0);
         if (i == 5) check("hyst_rts_level5", bus.RTS, 1);
      end
      check("hyst_level6", bus.Level, 6);
      check("hyst_rts_off", bus.RTS, 0);
      for (int i = 1; i <= 4; i++) begin
         step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0);
         if (i == 3) check("hyst_rts_level3", bus.RTS, 0);
      end
      check("hyst_level2", bus.Level, 2);
      check("hyst_rts_on", bus.RTS, 1);
      drain();

      // Overflow
      for (int i = 1; i <= 9; i++) step(1'b1, 8'(i), 3'b000, 1'b0, 1'b0);
      check("ovf_level", bus.Level, 8);
      check("ovf_flag", bus.Overrun, 1);
      for (int i = 1; i <= 8; i++) begin
         check("ovf_order", bus.Rd_Data, i);
         step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0);
      end
      check("ovf_sticky", bus.Overrun, 1);
      step(1'b0, 8'h00, 3'b000, 1'b0, 1'b1);
      check("ovf_cleared", bus.Overrun, 0);

      // Full plus simultaneous read and write
      for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h10 + i), 3'b000, 1'b0, 1'b0);
      step(1'b1, 8'hA5, 3'b000, 1'b1, 1'b0);
      check("frw_level", bus.Level, 8);
      check("frw_overrun", bus.Overrun, 0);
      for (int i = 0; i < 8; i++) begin
         check("frw_order", bus.Rd_Data, (i == 7) ? 32'hA5 : 32'h11 + i);
         step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0);
      end

      // Error tagging
      step(1'b0, 8'h00, 3'b000, 1'b0, 1'b1);
      step(1'b1, 8'h0C, 3'b001, 1'b0, 1'b0);
      step(1'b1, 8'h00, 3'b110, 1'b0, 1'b0);
      check("tag_data0", bus.Rd_Data, 8'h0C);
      check("tag_err0", bus.Rd_Error, 3'b001);
      check("tag_parity", bus.Parity_Cnt, 1);
      check("tag_frame", bus.Frame_Cnt, 1);
      check("tag_break", bus.Break_Cnt, 1);
      step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0);
      check("tag_err1", bus.Rd_Error, 3'b110);
      step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0);
      idle(BREAK_HOLD + 2);

      // Counter saturation, then clear beating a same-cycle increment
      for (int i = 0; i < 260; i++) step(1'b1, 8'(i), 3'b001, 1'b1, 1'b0);
      check("sat_parity", bus.Parity_Cnt, 255);
      check("sat_frame_untouched", bus.Frame_Cnt, 1);
      step(1'b1, 8'h77, 3'b011, 1'b1, 1'b1);
      check("clr_prio_parity", bus.Parity_Cnt, 0);
      check("clr_prio_frame", bus.Frame_Cnt, 0);
      drain();

      // Break hold, then a second break frame at hold cycle 10
      step(1'b1, 8'h42, 3'b100, 1'b0, 1'b0);
      check("brk_level", bus.Level, 1);
      measure_low(n);
      check("brk_low_cycles", n, BREAK_HOLD);
      check("brk_rts_after", bus.RTS, 1);
      drain();
      step(1'b1, 8'h43, 3'b100, 1'b0, 1'b0);
      idle(9);
      step(1'b1, 8'h44, 3'b100, 1'b0, 1'b0);
      measure_low(n);
      check("brk_reload_low_cycles", n, BREAK_HOLD);
      check("brk_reload_rts_after", bus.RTS, 1);
      drain();

      // Async reset mid-stream
      step(1'b1, 8'h01, 3'b001, 1'b0, 1'b0);
      step(1'b1, 8'h02, 3'b010, 1'b0, 1'b0);
      step(1'b1, 8'h03, 3'b000, 1'b0, 1'b0);
      step(1'b1, 8'h04, 3'b001, 1'b0, 1'b0);
      step(1'b1, 8'h05, 3'b100, 1'b0, 1'b0);
      check("pre_rst_level", bus.Level, 5);
      check("pre_rst_rts", bus.RTS, 0);
      check("pre_rst_parity", bus.Parity_Cnt, 2);
      #2 rst = 1'b0;
      #1;
      check("arst_rts", bus.RTS, 1);
      check("arst_valid", bus.Rd_Valid, 0);
      check("arst_level", bus.Level, 0);
      check("arst_parity", bus.Parity_Cnt, 0);
      check("arst_frame", bus.Frame_Cnt, 0);
      check("arst_break", bus.Break_Cnt, 0);
      check("arst_rd_data", bus.Rd_Data, 0);
      step(1'b1, 8'hEE, 3'b001, 1'b0, 1'b0);
      step(1'b1, 8'hEE, 3'b001, 1'b0, 1'b0);
      check("arst_no_write", bus.Level, 0);
      rst = 1'b1;
      step(1'b1, 8'h3C, 3'b000, 1'b0, 1'b0);
      check("post_rst_level", bus.Level, 1);
      check("post_rst_data", bus.Rd_Data, 8'h3C);
      step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0);

      // Random traffic with alternating consumer speed to reach full and empty
      for (int i = 0; i < 3000; i++) begin
         rdy_pct = ((i / 300) % 2 == 1) ? 80 : 25;
         dr      = ($urandom_range(0, 99) < 60);
         e       = {($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 7) == 0)};
         rdy     = ($urandom_range(0, 99) < rdy_pct);
         clr     = !dr && ($urandom_range(0, 63) == 0);
         step(dr, 8'($urandom), e, rdy, clr);
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
